// File: rtl/pc_br_ctrl_pkg.sv
// Shared widths, sizes and state encoding for the program-counter / branch-control unit.
package pc_br_ctrl_pkg;

    localparam int ADDR_W       = 4;
    localparam int OFF_W        = 6;
    localparam int ROM_DEPTH    = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 8;
    localparam int FC_W         = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pc_br_ctrl_br_target_calc.sv
// Branch target: branch address plus sign-extended offset, with a ROM range check.
module br_target_calc
    import pc_br_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] ex_inst_addr_i,
    input  logic [OFF_W-1:0]  jump_offset_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              out_of_range_o
);

    localparam int SW = ADDR_W + 2;
    localparam logic signed [SW-1:0] LAST_ADDR = SW'(ROM_DEPTH - 1);

    logic signed [SW-1:0] addr_ext;
    logic signed [SW-1:0] off_ext;
    logic signed [SW-1:0] sum;

    always_comb begin
        addr_ext       = {2'b00, ex_inst_addr_i};
        off_ext        = SW'($signed(jump_offset_i));
        sum            = addr_ext + off_ext;
        target_o       = sum[ADDR_W-1:0];
        out_of_range_o = sum[SW-1] | (sum > LAST_ADDR);
    end

endmodule

// File: rtl/pc_br_ctrl.sv
// PC sequencing with branch redirect, post-redirect flush window, end-of-ROM halt
// and a saturating taken-branch counter.
module pc_br_ctrl
    import pc_br_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              jump_en_i,
    input  logic [OFF_W-1:0]  jump_offset_i,
    input  logic [ADDR_W-1:0] ex_inst_addr_i,
    input  logic              ex_valid_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    output logic              flush_o,
    output logic              halt_o,
    output logic              range_err_o,
    output logic [CNT_W-1:0]  branch_cnt_o
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_DEPTH - 1);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] target;
    logic              out_of_range;
    logic              take;

    br_target_calc u_target (
        .ex_inst_addr_i (ex_inst_addr_i),
        .jump_offset_i  (jump_offset_i),
        .target_o       (target),
        .out_of_range_o (out_of_range)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fcnt_d  = fcnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        take    = jump_en_i & ex_valid_i & ((state_q == ST_RUN) | (state_q == ST_HALT));

        if (take) begin
            state_d = ST_FLUSH;
            pc_d    = target;
            fcnt_d  = FC_W'(FLUSH_CYCLES);
            cnt_d   = sat_inc(cnt_q);
            err_d   = err_q | out_of_range;
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_RUN;
                ST_RUN, ST_FLUSH: begin
                    if (state_q == ST_FLUSH) begin
                        fcnt_d = fcnt_q - FC_W'(1);
                        if (fcnt_q == FC_W'(1)) state_d = ST_RUN;
                    end
                    // Reaching the last ROM word stops fetch even inside a flush window.
                    if (!stall_i) begin
                        if (pc_q == LAST_PC) state_d = ST_HALT;
                        else                 pc_d    = pc_q + ADDR_W'(1);
                    end
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            pc_q    <= '0;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pc_o         = pc_q;
    assign inst_valid_o = (state_q == ST_RUN) | (state_q == ST_FLUSH);
    assign halt_o       = (state_q == ST_HALT);
    assign flush_o      = take & ~rst;
    assign range_err_o  = err_q;
    assign branch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_br_ctrl.sv
// Directed scenarios followed by random traffic, each cycle compared with a behavioural model.
module tb_pc_br_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall_i = 1'b0;
    logic       jump_en_i = 1'b0;
    logic [5:0] jump_offset_i = '0;
    logic [3:0] ex_inst_addr_i = '0;
    logic       ex_valid_i = 1'b0;
    logic [3:0] pc_o;
    logic       inst_valid_o, flush_o, halt_o, range_err_o;
    logic [7:0] branch_cnt_o;

    pc_br_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .jump_en_i      (jump_en_i),
        .jump_offset_i  (jump_offset_i),
        .ex_inst_addr_i (ex_inst_addr_i),
        .ex_valid_i     (ex_valid_i),
        .pc_o           (pc_o),
        .inst_valid_o   (inst_valid_o),
        .flush_o        (flush_o),
        .halt_o         (halt_o),
        .range_err_o    (range_err_o),
        .branch_cnt_o   (branch_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: fresh = first cycle after reset, halted = fetch stopped, ignore = blind cycles left.
    int m_pc, m_cnt, m_err, m_fresh, m_halted, m_ignore;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_err = 0; m_fresh = 1; m_halted = 0; m_ignore = 0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic r, input logic s, input logic je,
                       input logic [5:0] off, input logic [3:0] a, input logic ev);
        int t;
        int offs;
        logic take;
        rst = r; stall_i = s; jump_en_i = je; jump_offset_i = off;
        ex_inst_addr_i = a; ex_valid_i = ev;
        @(negedge clk);
        take = !r && je && ev && (m_fresh == 0) && (m_ignore == 0);
        chk("flush", 32'(flush_o), 32'(take));
        chk("pc", 32'(pc_o), 32'(m_pc));
        chk("valid", 32'(inst_valid_o), 32'((m_fresh == 0) && (m_halted == 0)));
        chk("halt", 32'(halt_o), 32'(m_halted));
        chk("range_err", 32'(range_err_o), 32'(m_err));
        chk("branch_cnt", 32'(branch_cnt_o), 32'(m_cnt));
        $display("cyc t=%0t rst=%0b stall=%0b jen=%0b ev=%0b addr=%0d off=%0d pc=%0d valid=%0b flush=%0b halt=%0b err=%0b cnt=%0d",
                 $time, r, s, je, ev, a, off, pc_o, inst_valid_o, flush_o, halt_o, range_err_o, branch_cnt_o);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (m_fresh != 0) begin
            m_fresh = 0;
        end else if (take) begin
            offs = (int'(off) >= 32) ? int'(off) - 64 : int'(off);
            t = int'(a) + offs;
            if (t > 31) t -= 64;
            if (t < 0 || t > 15) m_err = 1;
            m_pc = t & 15;
            if (m_cnt < 255) m_cnt++;
            m_ignore = 2;
            m_halted = 0;
        end else if (m_halted == 0) begin
            if (m_ignore > 0) m_ignore--;
            if (!s) begin
                if (m_pc == 15) begin
                    m_halted = 1;
                    m_ignore = 0;
                end else begin
                    m_pc++;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_pc", 32'(pc_o), 0);
        chk("rst_valid", 32'(inst_valid_o), 0);

        // Release reset, then sequential fetch.
        cyc(0, 0, 0, 0, 0, 0);
        chk("s1_pc0", 32'(pc_o), 0);
        chk("s1_valid", 32'(inst_valid_o), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("s1_seq", 32'(pc_o), 32'(i));
        end

        // Branch 6 + (-2) -> 4, then two ignored requests.
        cyc(0, 0, 1, 6'b111110, 4'd6, 1);
        chk("s2_pc", 32'(pc_o), 4);
        chk("s2_cnt", 32'(branch_cnt_o), 1);
        cyc(0, 0, 1, 6'b111110, 4'd6, 1);
        cyc(0, 0, 1, 6'b111110, 4'd6, 1);
        chk("s2_ignored_pc", 32'(pc_o), 6);
        chk("s2_ignored_cnt", 32'(branch_cnt_o), 1);

        // Run to end of ROM and halt; then branch out of HALT.
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("s3_pc15", 32'(pc_o), 15);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("s3_halt", 32'(halt_o), 1);
        chk("s3_valid", 32'(inst_valid_o), 0);
        chk("s3_pc_hold", 32'(pc_o), 15);
        cyc(0, 0, 1, 6'b110110, 4'd14, 1);
        chk("s3_redirect", 32'(pc_o), 4);
        chk("s3_unhalt", 32'(halt_o), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Out-of-range target 13 + 5 wraps to 2 and sets the sticky error.
        cyc(0, 0, 1, 6'd5, 4'd13, 1);
        chk("s4_pc", 32'(pc_o), 2);
        chk("s4_err", 32'(range_err_o), 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 6'd3, 4'd4, 1);
        chk("s4_pc7", 32'(pc_o), 7);
        chk("s4_err_sticky", 32'(range_err_o), 1);

        // Stall holds pc; take overrides stall.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("s5_stall_pc", 32'(pc_o), 7);
        chk("s5_stall_valid", 32'(inst_valid_o), 1);
        cyc(0, 1, 1, 6'b111110, 4'd5, 1);
        chk("s5_take_stall", 32'(pc_o), 3);
        chk("s5_cnt", 32'(branch_cnt_o), 5);

        // Reset in the middle of a flush window, with a branch request present.
        cyc(1, 0, 1, 6'd1, 4'd2, 1);
        chk("s6_pc", 32'(pc_o), 0);
        chk("s6_cnt", 32'(branch_cnt_o), 0);
        chk("s6_valid", 32'(inst_valid_o), 0);
        chk("s6_err", 32'(range_err_o), 0);

        // Continuous branch requests until the counter saturates.
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 900; i++)
            cyc(0, 1'($urandom_range(0, 3) == 0), 1, 6'($urandom), 4'($urandom), 1);
        chk("s6_saturate", 32'(branch_cnt_o), 255);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0), 6'($urandom), 4'($urandom),
                1'($urandom_range(0, 4) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
